seq_counter_prog: RTL and testbench

- Parametrised, programmable sequence counter. Successor to the fixed 3-bit 0→3→5→6→0 sequence counter.
- Steps through a run-time-loaded table of up to DEPTH codes of WIDTH bits.
- Supports forward, reverse, ping-pong and hold modes, a programmable sequence length, and a wrap/turnaround pulse.
- Used wherever the design needs a non-binary state or code sequencer: stepper phases, LED patterns, test-pattern generators.

---
 rtl/seq_counter_prog.sv | 175 +++++++++++++++++
 tb/tb_seq_counter_prog.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_counter_prog.sv
// Programmable sequence counter: steps through a run-time loaded table of
// codes in forward, reverse, ping-pong or hold mode over a programmable
// length, with a registered wrap/turnaround pulse and a length-error pulse.
module seq_counter_prog #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             len_we,
  input  logic [AW:0]      len_data,
  output logic [WIDTH-1:0] count,
  output logic [AW-1:0]    idx,
  output logic             wrap,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_REV  = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [AW:0]      len_q;
  logic             dir_up_q;

  logic             len_ok;
  logic             len_load;
  logic             addr_ok;
  logic [AW:0]      len_eff;
  logic [AW:0]      idx_w;
  logic [AW:0]      last;
  logic [AW:0]      last_m1;
  logic             step;

  logic             load;
  logic [AW-1:0]    nxt_idx;
  logic             nxt_dir_up;
  logic             nxt_wrap;
  logic [WIDTH-1:0] nxt_code;

  assign len_ok   = (len_data != '0) && (len_data <= DEPTH_L);
  assign len_load = len_we && len_ok;
  assign addr_ok  = ({1'b0, cfg_addr} < DEPTH_L);
  // A legal length written on this edge already governs this edge's step,
  // so the index never lands outside the new length.
  assign len_eff  = len_load ? len_data : len_q;
  assign idx_w    = {1'b0, idx};
  assign last     = len_eff - (AW+1)'(1);
  assign last_m1  = len_eff - (AW+1)'(2);
  assign step     = en && (mode_t'(mode) != MODE_HOLD);

  // Next index / direction / wrap selection, in edge priority order.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    load       = 1'b0;
    nxt_idx    = idx;
    nxt_dir_up = dir_up_q;
    nxt_wrap   = 1'b0;
    if (sync_clr) begin
      load       = 1'b1;
      nxt_idx    = '0;
      nxt_dir_up = 1'b1;
    end else if (len_load && (len_data <= idx_w)) begin
      load       = 1'b1;
      nxt_idx    = '0;
      nxt_dir_up = 1'b1;
    end else if (step) begin
      load = 1'b1;
      if (idx_w >= len_eff) begin
        // Out-of-range index recovers silently to the start.
        nxt_idx    = '0;
        nxt_dir_up = 1'b1;
      end else begin
        case (mode_t'(mode))
          MODE_FWD: begin
            if (idx_w == last) begin
              nxt_idx  = '0;
              nxt_wrap = 1'b1;
            end else begin
              nxt_idx = idx + AW'(1);
            end
          end
          MODE_REV: begin
            if (idx == '0) begin
              nxt_idx  = last[AW-1:0];
              nxt_wrap = 1'b1;
            end else begin
              nxt_idx = idx - AW'(1);
            end
          end
          MODE_PP: begin
            if (len_eff == (AW+1)'(1)) begin
              nxt_idx  = '0;
              nxt_wrap = 1'b1;
            end else if (dir_up_q) begin
              if (idx_w == last) begin
                nxt_idx    = last_m1[AW-1:0];
                nxt_dir_up = 1'b0;
                nxt_wrap   = 1'b1;
              end else begin
                nxt_idx = idx + AW'(1);
              end
            end else begin
              if (idx == '0) begin
                nxt_idx    = AW'(1);
                nxt_dir_up = 1'b1;
                nxt_wrap   = 1'b1;
              end else begin
                nxt_idx = idx - AW'(1);
              end
            end
          end
          default: begin
            nxt_idx = idx;
          end
        endcase
      end
    end
  end

  // Code for the index being loaded, with write-first bypass of a same-edge table write.
  always_comb begin
    nxt_code = table_q[nxt_idx];
    if (cfg_we && (cfg_addr == nxt_idx)) begin
      nxt_code = cfg_data;
    end
  end

  // Table, length, index, count and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the table is reset on purpose: its identity contents are part of
      // the reset state, so it must live in flops rather than a plain RAM.
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= WIDTH'(i);
      end
      len_q    <= DEPTH_L;
      idx      <= '0;
      dir_up_q <= 1'b1;
      count    <= '0;
      wrap     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      if (cfg_we && addr_ok) begin
        table_q[cfg_addr] <= cfg_data;
      end
      if (len_load) begin
        len_q <= len_data;
      end
      if (load) begin
        idx   <= nxt_idx;
        count <= nxt_code;
      end
      dir_up_q <= nxt_dir_up;
      wrap     <= nxt_wrap;
      cfg_err  <= len_we && !len_ok;
    end
  end

endmodule

// File: tb/tb_seq_counter_prog.sv
// Self-checking bench for seq_counter_prog: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against an
// integer-level model of the sequencer.
module tb_seq_counter_prog;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic [1:0]       mode;
  logic             sync_clr;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             len_we;
  logic [AW:0]      len_data;
  logic [WIDTH-1:0] count;
  logic [AW-1:0]    idx;
  logic             wrap;
  logic             cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  seq_counter_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .mode     (mode),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .len_we   (len_we),
    .len_data (len_data),
    .count    (count),
    .idx      (idx),
    .wrap     (wrap),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as plain integers.
  int m_table [DEPTH];
  int m_len;
  int m_idx;
  int m_dir;   // +1 climbing, -1 descending
  int m_count;
  int m_wrap;
  int m_err;
  bit model_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_table[i] = i % (1 << WIDTH);
    m_len = DEPTH; m_idx = 0; m_dir = 1; m_count = 0; m_wrap = 0; m_err = 0;
  endtask

  // One clock edge of the sequencer, from its behavioural rules.
  task automatic model_step();
    int  ld  = int'(len_data);
    bit  legal = (ld >= 1) && (ld <= DEPTH);
    bit  go  = en && (mode != 2'b11);
    int  p;
    if (cfg_we) m_table[int'(cfg_addr)] = int'(cfg_data);  // write-first
    m_err  = (len_we && !legal) ? 1 : 0;
    m_wrap = 0;
    if (len_we && legal) m_len = ld;
    if (sync_clr || (len_we && legal && m_len <= m_idx)) begin
      m_idx = 0; m_dir = 1; m_count = m_table[0];
    end else if (go) begin
      if (m_idx >= m_len) begin
        m_idx = 0; m_dir = 1;
      end else if (mode == 2'b00) begin
        m_wrap = (m_idx == m_len - 1) ? 1 : 0;
        m_idx  = (m_idx + 1) % m_len;
      end else if (mode == 2'b01) begin
        m_wrap = (m_idx == 0) ? 1 : 0;
        m_idx  = (m_idx + m_len - 1) % m_len;
      end else if (m_len == 1) begin
        m_wrap = 1;
      end else begin
        p = m_idx + m_dir;
        if (p < 0 || p >= m_len) begin
          m_dir  = -m_dir;
          m_wrap = 1;
          p      = m_idx + m_dir;
        end
        m_idx = p;
      end
      m_count = m_table[m_idx];
    end
  endtask

  // Compare process: advance the model on each live edge, check just after it.
  always @(posedge clk) begin
    if (model_on && reset_n) begin
      model_step();
      #1;
      check("count", int'(count), m_count);
      check("idx", int'(idx), m_idx);
      check("wrap", int'(wrap), m_wrap);
      check("cfg_err", int'(cfg_err), m_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 0; mode = 2'b00; sync_clr = 0; cfg_we = 0; cfg_addr = '0;
    cfg_data = '0; len_we = 0; len_data = '0;
  endtask

  int fwd_c [8] = '{3, 5, 6, 0, 3, 5, 6, 0};
  int fwd_w [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int rev_c [8] = '{6, 5, 3, 0, 6, 5, 3, 0};
  int rev_w [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  int pp_c  [8] = '{3, 5, 6, 5, 3, 0, 3, 5};
  int pp_w  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  int prog_c[4] = '{0, 3, 5, 6};

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) tick();
    check("reset_count", int'(count), 0);
    check("reset_idx", int'(idx), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_cfg_err", int'(cfg_err), 0);
    reset_n  = 1'b1;
    model_on = 1'b1;

    // Program the 0,3,5,6 sequence and length 4.
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1; cfg_addr = AW'(i); cfg_data = WIDTH'(prog_c[i]);
      tick();
    end
    cfg_we = 0; len_we = 1; len_data = 4'd4;
    tick();
    len_we = 0;

    en = 1; mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fwd_count", int'(count), fwd_c[i]);
      check("fwd_wrap", int'(wrap), fwd_w[i]);
    end
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rev_count", int'(count), rev_c[i]);
      check("rev_wrap", int'(wrap), rev_w[i]);
    end
    mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("pp_count", int'(count), pp_c[i]);
      check("pp_wrap", int'(wrap), pp_w[i]);
    end

    // Forward one step to idx 3, then shrink length to 2 on the next edge.
    mode = 2'b00;
    tick();
    check("at3_idx", int'(idx), 3);
    check("at3_count", int'(count), 6);
    len_we = 1; len_data = 4'd2;
    tick();
    len_we = 0;
    check("shrink_idx", int'(idx), 0);
    check("shrink_count", int'(count), 0);
    check("shrink_wrap", int'(wrap), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("len2_count", int'(count), (i % 2 == 0) ? 3 : 0);
      check("len2_wrap", int'(wrap), (i % 2 == 0) ? 0 : 1);
    end

    // Restore length 4 while stopped, then two illegal length writes.
    en = 0; len_we = 1; len_data = 4'd4;
    tick();
    len_data = 4'd0;
    tick();
    check("err_len0", int'(cfg_err), 1);
    len_we = 0;
    tick();
    check("err_clear", int'(cfg_err), 0);
    len_we = 1; len_data = 4'd9;
    tick();
    check("err_len9", int'(cfg_err), 1);
    len_we = 0;
    tick();
    check("err_clear2", int'(cfg_err), 0);

    // Same-edge table write to the entry being entered takes the new code.
    en = 1; mode = 2'b00; cfg_we = 1; cfg_addr = 3'd1; cfg_data = 3'd7;
    tick();
    cfg_we = 0;
    check("bypass_count", int'(count), 7);
    check("bypass_idx", int'(idx), 1);
    tick(); check("len4_a", int'(count), 5);
    tick(); check("len4_b", int'(count), 6);
    tick(); check("len4_c", int'(count), 0);
    check("len4_wrap", int'(wrap), 1);

    // Hold mode, then en low, each for 5 cycles; a write to the current entry
    // must not disturb count.
    mode = 2'b11; cfg_we = 1; cfg_addr = 3'd0; cfg_data = 3'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      cfg_we = 0;
      check("hold_count", int'(count), 0);
      check("hold_wrap", int'(wrap), 0);
    end
    mode = 2'b00; en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en0_count", int'(count), 0);
    end

    // Advance to a nonzero index, then reset asynchronously mid-cycle.
    en = 1;
    tick(); check("pre_rst_a", int'(count), 7);
    tick(); check("pre_rst_b", int'(count), 5);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_idx", int'(idx), 0);
    tick();
    reset_n = 1'b1; en = 1; mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_count", int'(count), (i + 1) % 8);
      check("post_rst_wrap", int'(wrap), (i == 7) ? 1 : 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      en       = ($urandom_range(0, 9) < 8);
      mode     = 2'($urandom_range(0, 3));
      sync_clr = ($urandom_range(0, 31) == 0);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = AW'($urandom_range(0, DEPTH - 1));
      cfg_data = WIDTH'($urandom);
      len_we   = ($urandom_range(0, 11) == 0);
      len_data = (AW+1)'($urandom_range(0, 15));
      tick();
    end

    idle_inputs();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
